cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Shares the single pipelined main memory between the I-cache miss handler and the D-cache miss/store path of the 16-bit pipelined CPU.
- Sequences 8-word block fills for both caches and single-word write-through stores.
- Exposes a fill-write interface per cache and a busy flag that feeds the pipeline stall logic.

Parameters:
- DATA_W, 16, data word width
- ADDR_W, 16, byte address width
- BLOCK_WORDS, 8, words per cache block (16 bytes)
- MEM_LAT, 4, cycles from memory read issue to mem_valid

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- ic_miss_req  in  1  I-cache miss pending; held until ic_fill_done
- ic_miss_addr  in  16  I-cache miss byte address
- dc_miss_req  in  1  D-cache miss pending; held until dc_fill_done
- dc_miss_addr  in  16  D-cache miss byte address
- dc_wr_req  in  1  store pending; held until dc_wr_ack
- dc_wr_addr  in  16  store byte address
- dc_wr_data  in  16  store data
- mem_rdata  in  16  memory read data
- mem_valid  in  1  mem_rdata valid this cycle
- mem_en  out  1  memory access this cycle
- mem_wr  out  1  access is a write
- mem_addr  out  16  memory byte address
- mem_wdata  out  16  memory write data
- fill_data  out  16  returned word, shared by both caches
- fill_word  out  3  word index within block
- ic_fill_we  out  1  write fill_data into I-cache at fill_word
- dc_fill_we  out  1  write fill_data into D-cache at fill_word
- ic_fill_done  out  1  one-cycle pulse, I-cache block complete
- dc_fill_done  out  1  one-cycle pulse, D-cache block complete
- dc_wr_ack  out  1  one-cycle pulse, store issued
- busy  out  1  arbiter not IDLE

Behaviour:
- States: DRAIN, IDLE, FILL_I, FILL_D, WRITE.
- Reset: all outputs 0; state DRAIN; counters 0.
- DRAIN:
  - Lasts MEM_LAT cycles; busy=1.
  - Ignores mem_valid so returns from reads issued before reset are discarded.
  - Then goes to IDLE.
- IDLE: grant priority is dc_wr_req > dc_miss_req > ic_miss_req, with a starvation guard:
  - If ic_miss_req is pending and the previous grant went to the D side, the I side wins.
  - Grant latches the block base {addr[15:4],4'h0} (or the store addr/data) and moves to the target state next cycle.
- FILL_x:
  - Issue counter k=0..7: mem_en=1, mem_wr=0, mem_addr=base+2k in consecutive cycles (first issue in the cycle after grant).
  - Return counter increments on each mem_valid.
  - Each return drives fill_data=mem_rdata, fill_word=return count, and x_fill_we=1.
  - On the 8th return, x_fill_done=1 in the same cycle as the last fill_we; next state is IDLE.
  - Fill latency: grant cycle G; issues G+1..G+8; returns G+1+MEM_LAT .. G+8+MEM_LAT; done at G+12 by default.
- WRITE:
  - One cycle: mem_en=1, mem_wr=1, mem_addr=latched addr, mem_wdata=latched data, dc_wr_ack=1.
  - Next state is IDLE.
- New grant possible in the IDLE cycle directly after done/ack. No overlap of transactions.
- mem_valid outside FILL_x is ignored.
- Request deassertion mid-transaction is a protocol violation; the transaction completes regardless.
- Reset mid-fill: abort immediately, no done pulse, enter DRAIN.
- Address width: base+2k never carries out of the block; offset bits [3:1] come from k.
- busy=1 in every state except IDLE.

Decomposition:
- Package cache_pkg:
  - Arbiter state enum.
  - BLOCK_WORDS, MEM_LAT.
  - WORD_IDX_W=3 and BLOCK_OFF_W=4 constants.
  - Owner encoding (OWN_I, OWN_D).
- One sub-module, fill_sequencer:
  - Issue/return counters, address generation, last-return detect.
  - Instantiated once; the top-level FSM muxes its outputs to the I or D side.

Test Plan:
- I-miss alone:
  - Stimulus: ic_miss_addr=0x1236; memory returns 0xA000+k.
  - Required: reads 0x1230..0x123E, ic_fill_we ×8 with fill_word 0..7 and data 0xA000..0xA007, ic_fill_done exactly 12 cycles after grant; dc_fill_we never asserted.
- Simultaneous dc_miss_req (0x4000) and ic_miss_req (0x8000):
  - Required: D fill completes first, I grant on the next IDLE cycle, addresses 0x8000..0x800E.
- Starvation guard:
  - Stimulus: dc_wr_req held continuously with a new store after each ack, while ic_miss_req is pending.
  - Required: the I fill is granted after at most one D transaction.
- Store:
  - Stimulus: dc_wr_addr=0x00F2, dc_wr_data=0xBEEF.
  - Required: single cycle with mem_en=1, mem_wr=1, addr 0x00F2, data 0xBEEF, dc_wr_ack=1; busy low the next cycle.
- Reset mid-fill after 3 returns:
  - Required: outputs 0; no done pulse; stale mem_valid pulses during the 4 DRAIN cycles produce no fill_we.
  - A following I-miss fills all 8 words correctly.

Source files
------------

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the cache/main-memory arbiter.
package cache_pkg;

  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 16;
  localparam int BLOCK_WORDS = 8;
  localparam int MEM_LAT     = 4;
  localparam int WORD_IDX_W  = 3;
  localparam int BLOCK_OFF_W = 4;

  typedef enum logic [2:0] {
    ST_DRAIN,
    ST_IDLE,
    ST_FILL_I,
    ST_FILL_D,
    ST_WRITE
  } arb_state_t;

  // Which cache received the most recent grant.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Align a byte address down to the start of its cache block.
  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:BLOCK_OFF_W], {BLOCK_OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache-side request/fill signals and main-memory bus, bundled as one interface.
interface cache_mem_arbiter_if;
  import cache_pkg::*;

  logic              ic_miss_req;
  logic [ADDR_W-1:0] ic_miss_addr;
  logic              dc_miss_req;
  logic [ADDR_W-1:0] dc_miss_addr;
  logic              dc_wr_req;
  logic [ADDR_W-1:0] dc_wr_addr;
  logic [DATA_W-1:0] dc_wr_data;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] fill_data;
  logic [WORD_IDX_W-1:0] fill_word;
  logic              ic_fill_we;
  logic              dc_fill_we;
  logic              ic_fill_done;
  logic              dc_fill_done;
  logic              dc_wr_ack;
  logic              busy;

  // Arbiter side.
  modport slave (
    input  ic_miss_req, ic_miss_addr, dc_miss_req, dc_miss_addr,
           dc_wr_req, dc_wr_addr, dc_wr_data, mem_rdata, mem_valid,
    output mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
           ic_fill_we, dc_fill_we, ic_fill_done, dc_fill_done, dc_wr_ack, busy
  );

  // Caches plus memory side.
  modport master (
    output ic_miss_req, ic_miss_addr, dc_miss_req, dc_miss_addr,
           dc_wr_req, dc_wr_addr, dc_wr_data, mem_rdata, mem_valid,
    input  mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
           ic_fill_we, dc_fill_we, ic_fill_done, dc_fill_done, dc_wr_ack, busy
  );
endinterface

// File: rtl/cache_mem_arbiter_fill_sequencer.sv
// Block-fill sequencer: issues 8 consecutive word reads and tracks returns.
module fill_sequencer
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_active,
  input  logic                  i_mem_valid,
  input  logic [ADDR_W-1:0]     i_base,
  output logic                  o_issue,
  output logic [ADDR_W-1:0]     o_addr,
  output logic                  o_ret,
  output logic [WORD_IDX_W-1:0] o_word,
  output logic                  o_last
);

  // Extra MSB on the issue counter marks "all words issued".
  logic [WORD_IDX_W:0]   r_iss_cnt;
  logic [WORD_IDX_W-1:0] r_ret_cnt;

  // Issue and return counters, cleared at every grant.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values, independent of block order.
    if (!rst_n || i_start) begin
      r_iss_cnt <= '0;
      r_ret_cnt <= '0;
    end else if (i_active) begin
      if (!r_iss_cnt[WORD_IDX_W]) r_iss_cnt <= r_iss_cnt + 1'b1;
      if (i_mem_valid)            r_ret_cnt <= r_ret_cnt + 1'b1;
    end
  end

  // Word offset comes straight from the counter, so the address never leaves the block.
  assign o_issue = i_active && !r_iss_cnt[WORD_IDX_W];
  assign o_addr  = {i_base[ADDR_W-1:BLOCK_OFF_W], r_iss_cnt[WORD_IDX_W-1:0], 1'b0};
  assign o_ret   = i_active && i_mem_valid;
  assign o_word  = r_ret_cnt;
  assign o_last  = o_ret && (r_ret_cnt == WORD_IDX_W'(BLOCK_WORDS - 1));

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates main memory between I-cache fills, D-cache fills and D-cache stores.
module cache_mem_arbiter
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  cache_mem_arbiter_if.slave  bus
);

  localparam int DRAIN_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  arb_state_t        r_state, w_next;
  logic [DRAIN_W-1:0] r_drain_cnt;
  owner_t            r_last_own;
  logic [ADDR_W-1:0] r_base, r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  logic                  w_start, w_fill_active;
  logic                  w_seq_issue, w_seq_ret, w_seq_last;
  logic [ADDR_W-1:0]     w_seq_addr;
  logic [WORD_IDX_W-1:0] w_seq_word;

  logic                  w_mem_en, w_mem_wr, w_ic_we, w_dc_we, w_ic_done, w_dc_done, w_ack, w_busy;
  logic [ADDR_W-1:0]     w_mem_addr;
  logic [DATA_W-1:0]     w_mem_wdata, w_fill_data;
  logic [WORD_IDX_W-1:0] w_fill_word;

  assign w_start       = (r_state == ST_IDLE) && (w_next != ST_IDLE);
  assign w_fill_active = (r_state == ST_FILL_I) || (r_state == ST_FILL_D);

  fill_sequencer u_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_start),
    .i_active    (w_fill_active),
    .i_mem_valid (bus.mem_valid),
    .i_base      (r_base),
    .o_issue     (w_seq_issue),
    .o_addr      (w_seq_addr),
    .o_ret       (w_seq_ret),
    .o_word      (w_seq_word),
    .o_last      (w_seq_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_DRAIN;
    else        r_state <= w_next;
  end

  // Drain timer and grant-time latches of address, data and owner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drain_cnt <= '0;
      r_last_own  <= OWN_I;
      r_base      <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + 1'b1 : '0;
      if (w_start) begin
        case (w_next)
          ST_FILL_I: begin r_base <= block_base(bus.ic_miss_addr); r_last_own <= OWN_I; end
          ST_FILL_D: begin r_base <= block_base(bus.dc_miss_addr); r_last_own <= OWN_D; end
          ST_WRITE:  begin
            r_wr_addr  <= bus.dc_wr_addr;
            r_wr_data  <= bus.dc_wr_data;
            r_last_own <= OWN_D;
          end
          default: ;
        endcase
      end
    end
  end

  // Next state: drain timeout, prioritised grant with I-side starvation guard, completion.
  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    case (r_state)
      ST_DRAIN:  if (r_drain_cnt == DRAIN_W'(MEM_LAT - 1)) w_next = ST_IDLE;
      ST_IDLE: begin
        if (bus.ic_miss_req && (r_last_own == OWN_D)) w_next = ST_FILL_I;
        else if (bus.dc_wr_req)                        w_next = ST_WRITE;
        else if (bus.dc_miss_req)                      w_next = ST_FILL_D;
        else if (bus.ic_miss_req)                      w_next = ST_FILL_I;
      end
      ST_FILL_I, ST_FILL_D: if (w_seq_last) w_next = ST_IDLE;
      ST_WRITE:  w_next = ST_IDLE;
      default:   w_next = ST_DRAIN;
    endcase
  end

  // Outputs; held at 0 while rst_n is low so a reset aborts a fill in the same cycle.
  always_comb begin
    w_mem_en    = 1'b0;
    w_mem_wr    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_fill_data = '0;
    w_fill_word = '0;
    w_ic_we     = 1'b0;
    w_dc_we     = 1'b0;
    w_ic_done   = 1'b0;
    w_dc_done   = 1'b0;
    w_ack       = 1'b0;
    w_busy      = 1'b0;
    if (rst_n) begin
      w_busy = (r_state != ST_IDLE);
      case (r_state)
        ST_FILL_I, ST_FILL_D: begin
          w_mem_en   = w_seq_issue;
          w_mem_addr = w_seq_issue ? w_seq_addr : '0;
          if (w_seq_ret) begin
            w_fill_data = bus.mem_rdata;
            w_fill_word = w_seq_word;
          end
          if (r_state == ST_FILL_I) begin
            w_ic_we   = w_seq_ret;
            w_ic_done = w_seq_last;
          end else begin
            w_dc_we   = w_seq_ret;
            w_dc_done = w_seq_last;
          end
        end
        ST_WRITE: begin
          w_mem_en    = 1'b1;
          w_mem_wr    = 1'b1;
          w_mem_addr  = r_wr_addr;
          w_mem_wdata = r_wr_data;
          w_ack       = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_en       = w_mem_en;
  assign bus.mem_wr       = w_mem_wr;
  assign bus.mem_addr     = w_mem_addr;
  assign bus.mem_wdata    = w_mem_wdata;
  assign bus.fill_data    = w_fill_data;
  assign bus.fill_word    = w_fill_word;
  assign bus.ic_fill_we   = w_ic_we;
  assign bus.dc_fill_we   = w_dc_we;
  assign bus.ic_fill_done = w_ic_done;
  assign bus.dc_fill_done = w_dc_done;
  assign bus.dc_wr_ack    = w_ack;
  assign bus.busy         = w_busy;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: scoreboarded fills, store table, corner sequences.
module tb_cache_mem_arbiter;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_mem_arbiter_if bus();

  cache_mem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       is_d;
    logic [2:0] word;
    logic [15:0] data;
    logic       last;
  } fill_exp_t;

  typedef struct {
    logic [15:0] miss_addr;
    logic [15:0] exp_base;
  } miss_vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp_addr;
    logic [15:0] exp_wdata;
  } store_vec_t;

  fill_exp_t   fill_q[$];
  logic [15:0] rd_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic stale_inj = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Memory contents: block 0x123x returns 0xA000+word, everything else addr^0xC3C3.
  function automatic logic [15:0] mem_data(input logic [15:0] a);
    if (a[15:4] == 12'h123) return 16'hA000 + {13'd0, a[3:1]};
    return a ^ 16'hC3C3;
  endfunction

  function automatic logic [63:0] outs_vec();
    return {5'd0, bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.fill_data,
            bus.fill_word, bus.ic_fill_we, bus.dc_fill_we, bus.ic_fill_done,
            bus.dc_fill_done, bus.dc_wr_ack, bus.busy};
  endfunction

  // Pipelined memory model: a read seen in cycle c returns in cycle c+MEM_LAT.
  logic        pv[MEM_LAT];
  logic [15:0] pd[MEM_LAT];
  initial begin
    logic        s_v;
    logic [15:0] s_a;
    bus.mem_valid = 1'b0;
    bus.mem_rdata = 16'h0;
    for (int i = 0; i < MEM_LAT; i++) begin pv[i] = 1'b0; pd[i] = 16'h0; end
    forever begin
      @(negedge clk);
      s_v = (bus.mem_en === 1'b1) && (bus.mem_wr === 1'b0);
      s_a = bus.mem_addr;
      @(posedge clk);
      #1;
      for (int i = MEM_LAT - 1; i > 0; i--) begin pv[i] = pv[i-1]; pd[i] = pd[i-1]; end
      pv[0] = s_v;
      pd[0] = mem_data(s_a);
      bus.mem_valid = pv[MEM_LAT-1] | stale_inj;
      bus.mem_rdata = pv[MEM_LAT-1] ? pd[MEM_LAT-1] : 16'hDEAD;
    end
  end

  task automatic expect_fill(input logic is_d, input logic [15:0] base);
    logic [15:0] a;
    for (int k = 0; k < BLOCK_WORDS; k++) begin
      a = base + 16'(2 * k);
      rd_q.push_back(a);
      fill_q.push_back('{is_d: is_d, word: 3'(k), data: mem_data(a), last: (k == BLOCK_WORDS - 1)});
    end
  endtask

  // Advance to the next negedge and scoreboard whatever the DUT shows.
  task automatic tick();
    fill_exp_t e;
    logic [15:0] ea;
    @(negedge clk);
    check("we_exclusive", {63'd0, bus.ic_fill_we & bus.dc_fill_we}, 64'd0);
    if (bus.ic_fill_we || bus.dc_fill_we) begin
      if (fill_q.size() == 0) begin
        check("fill_unexpected", {62'd0, bus.ic_fill_we, bus.dc_fill_we}, 64'd0);
      end else begin
        e = fill_q.pop_front();
        check("fill_side", {63'd0, bus.dc_fill_we}, {63'd0, e.is_d});
        check("fill_word", {61'd0, bus.fill_word}, {61'd0, e.word});
        check("fill_data", {48'd0, bus.fill_data}, {48'd0, e.data});
        check("fill_done", {62'd0, bus.ic_fill_done, bus.dc_fill_done},
              {62'd0, e.last & ~e.is_d, e.last & e.is_d});
      end
    end else if (bus.ic_fill_done || bus.dc_fill_done) begin
      check("done_without_we", {62'd0, bus.ic_fill_done, bus.dc_fill_done}, 64'd0);
    end
    if (bus.mem_en && !bus.mem_wr) begin
      if (rd_q.size() == 0) begin
        check("read_unexpected", {48'd0, bus.mem_addr}, 64'hFFFF_FFFF);
      end else begin
        ea = rd_q.pop_front();
        check("read_addr", {48'd0, bus.mem_addr}, {48'd0, ea});
      end
    end
  endtask

  // Wait (bounded) for a done pulse; drops that side's request in the done cycle.
  task automatic wait_done(input logic is_d, input int limit, output int cycles);
    for (int c = 0; c <= limit; c++) begin
      tick();
      if (is_d ? bus.dc_fill_done : bus.ic_fill_done) begin
        if (is_d) bus.dc_miss_req = 1'b0;
        else      bus.ic_miss_req = 1'b0;
        cycles = c;
        return;
      end
    end
    cycles = limit + 1;
    n_checks++;
    n_fail++;
    $display("FAIL wait_done_timeout: side=%0d no done within %0d cycles", is_d, limit);
  endtask

  task automatic do_reset(input logic inj);
    int n;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.ic_miss_req = 1'b0;
    bus.dc_miss_req = 1'b0;
    bus.dc_wr_req   = 1'b0;
    fill_q.delete();
    rd_q.delete();
    repeat (2) begin
      tick();
      check("reset_outputs", outs_vec(), 64'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) stale_inj = inj;
      check("drain_no_fill", {60'd0, bus.ic_fill_we, bus.dc_fill_we, bus.ic_fill_done, bus.dc_fill_done}, 64'd0);
      if (!bus.busy) break;
      n++;
    end
    stale_inj = 1'b0;
    check("drain_cycles", 64'(n), 64'(MEM_LAT));
  endtask

  task automatic i_miss(input logic [15:0] addr, input logic [15:0] base);
    int cyc;
    @(posedge clk);
    #1;
    bus.ic_miss_addr = addr;
    bus.ic_miss_req  = 1'b1;
    expect_fill(1'b0, base);
    wait_done(1'b0, 30, cyc);
    check("ic_done_latency", 64'(cyc), 64'd12);
  endtask

  initial begin
    miss_vec_t  miss_tbl[3];
    store_vec_t store_tbl[3];
    int cyc, n_acks, acks_before, n_we;
    logic seen_i, done_seen;

    miss_tbl[0] = '{16'h1236, 16'h1230};
    miss_tbl[1] = '{16'hFFFE, 16'hFFF0};
    miss_tbl[2] = '{16'h0401, 16'h0400};
    store_tbl[0] = '{16'h00F2, 16'hBEEF, 16'h00F2, 16'hBEEF};
    store_tbl[1] = '{16'hFFFE, 16'h0001, 16'hFFFE, 16'h0001};
    store_tbl[2] = '{16'h1000, 16'h5A5A, 16'h1000, 16'h5A5A};

    bus.ic_miss_req  = 1'b0;
    bus.ic_miss_addr = 16'h0;
    bus.dc_miss_req  = 1'b0;
    bus.dc_miss_addr = 16'h0;
    bus.dc_wr_req    = 1'b0;
    bus.dc_wr_addr   = 16'h0;
    bus.dc_wr_data   = 16'h0;

    do_reset(1'b0);

    // I-miss alone, including a block at the top of memory (no carry out of the block).
    foreach (miss_tbl[i]) i_miss(miss_tbl[i].miss_addr, miss_tbl[i].exp_base);

    // Simultaneous D and I misses: D first, I granted on the next IDLE cycle.
    @(posedge clk);
    #1;
    bus.dc_miss_addr = 16'h4000;
    bus.ic_miss_addr = 16'h8000;
    bus.dc_miss_req  = 1'b1;
    bus.ic_miss_req  = 1'b1;
    expect_fill(1'b1, 16'h4000);
    expect_fill(1'b0, 16'h8000);
    wait_done(1'b1, 30, cyc);
    check("dc_done_latency", 64'(cyc), 64'd12);
    wait_done(1'b0, 30, cyc);
    check("ic_after_dc_latency", 64'(cyc), 64'd12);

    // Starvation guard: continuous stores while an I-miss waits.
    @(posedge clk);
    #1;
    bus.ic_miss_addr = 16'h2340;
    bus.ic_miss_req  = 1'b1;
    bus.dc_wr_addr   = 16'h0010;
    bus.dc_wr_data   = 16'h1111;
    bus.dc_wr_req    = 1'b1;
    expect_fill(1'b0, 16'h2340);
    n_acks = 0;
    acks_before = -1;
    seen_i = 1'b0;
    done_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.mem_en && !bus.mem_wr && !seen_i) begin
        seen_i = 1'b1;
        acks_before = n_acks;
      end
      if (bus.dc_wr_ack) begin
        n_acks++;
        bus.dc_wr_addr = bus.dc_wr_addr + 16'd2;
        bus.dc_wr_data = bus.dc_wr_data + 16'd1;
      end
      if (bus.ic_fill_done) begin
        bus.ic_miss_req = 1'b0;
        bus.dc_wr_req   = 1'b0;
        done_seen = 1'b1;
        break;
      end
    end
    bus.dc_wr_req = 1'b0;
    check("starve_done_seen", {63'd0, done_seen}, 64'd1);
    check("starve_stores_before_i", 64'(acks_before), 64'd1);

    // Single-word stores.
    foreach (store_tbl[i]) begin
      @(posedge clk);
      #1;
      bus.dc_wr_addr = store_tbl[i].addr;
      bus.dc_wr_data = store_tbl[i].data;
      bus.dc_wr_req  = 1'b1;
      tick();
      check("store_grant_cycle_idle", {62'd0, bus.mem_en, bus.dc_wr_ack}, 64'd0);
      tick();
      check("store_ctrl", {60'd0, bus.mem_en, bus.mem_wr, bus.dc_wr_ack, bus.busy}, 64'hF);
      check("store_addr", {48'd0, bus.mem_addr}, {48'd0, store_tbl[i].exp_addr});
      check("store_wdata", {48'd0, bus.mem_wdata}, {48'd0, store_tbl[i].exp_wdata});
      bus.dc_wr_req = 1'b0;
      tick();
      check("store_after", {62'd0, bus.busy, bus.dc_wr_ack}, 64'd0);
    end

    // Reset after 3 returns of an I fill, with stale returns during DRAIN.
    @(posedge clk);
    #1;
    bus.ic_miss_addr = 16'h1236;
    bus.ic_miss_req  = 1'b1;
    expect_fill(1'b0, 16'h1230);
    n_we = 0;
    for (int c = 0; c < 30 && n_we < 3; c++) begin
      tick();
      if (bus.ic_fill_we) n_we++;
    end
    check("midfill_returns_seen", 64'(n_we), 64'd3);
    do_reset(1'b1);
    i_miss(16'h1236, 16'h1230);

    check("fill_q_empty", 64'(fill_q.size()), 64'd0);
    check("rd_q_empty", 64'(rd_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
